// File: rtl/adc_con.sv
// Serial capture controller for an AD7476-style ADC: generates cs_n/sclk, shifts in one frame.
// Define ADC_ZERO_CHECK_EN to flag frames whose leading (non-data) bits are not all zero.
module adc_con #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned QUIET_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sdata,
  output logic                 cs_n,
  output logic                 sclk,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err
);

  localparam int unsigned CntMax = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned BitW   = $clog2(FRAME_BITS + 1);
`ifdef ADC_ZERO_CHECK_EN
  localparam int unsigned ShW = FRAME_BITS;
`else
  // Leading bits are never inspected, so they are simply shifted out.
  localparam int unsigned ShW = DATA_BITS;
`endif

  typedef enum logic [1:0] {StIdle, StConv, StQuiet} state_e;

  state_e          state;
  logic [CntW-1:0] div_cnt;
  logic [BitW-1:0] bit_cnt;
  logic [ShW-1:0]  shift;
  logic            tick;

  assign tick = (div_cnt == CntW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cs_n       <= 1'b1;
      sclk       <= 1'b1;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
`ifdef ADC_ZERO_CHECK_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            cs_n    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= StConv;
          end
        end
        StConv: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt == BitW'(FRAME_BITS)) begin
              // sclk is already high after the last rising edge and stays there.
              cs_n       <= 1'b1;
              data_out   <= shift[DATA_BITS-1:0];
              data_valid <= 1'b1;
`ifdef ADC_ZERO_CHECK_EN
              frame_err  <= |shift[FRAME_BITS-1:DATA_BITS];
`endif
              if (QUIET_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= StIdle;
              end else begin
                state <= StQuiet;
              end
            end else begin
              sclk <= ~sclk;
              if (!sclk) begin
                shift   <= {shift[ShW-2:0], sdata};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        StQuiet: begin
          if (div_cnt == CntW'(QUIET_CYCLES - 1)) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          cs_n  <= 1'b1;
          sclk  <= 1'b1;
        end
      endcase
    end
  end

`ifndef ADC_ZERO_CHECK_EN
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_con.sv
// Directed bench for adc_con: default instance plus a CLK_DIV=4 instance, each with an ADC model.
module tb_adc_con;

`ifdef ADC_ZERO_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic clk, rst_n;
  logic start, sdata, cs_n, sclk, busy, data_valid, frame_err;
  logic [11:0] data_out;
  logic start4, sdata4, cs_n4, sclk4, busy4, data_valid4, frame_err4;
  logic [11:0] data_out4;

  int tests = 0;
  int fails = 0;
  int rises = 0;
  int dv_cnt = 0;
  int idx = 15;
  int idx4 = 15;
  logic [15:0] word = '0;
  logic [15:0] word4 = '0;
  time t_prev4 = 0;
  time t_per4 = 0;

  adc_con dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err)
  );

  adc_con #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sdata(sdata4), .cs_n(cs_n4), .sclk(sclk4),
    .busy(busy4), .data_out(data_out4), .data_valid(data_valid4), .frame_err(frame_err4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ADC models: word shifted out MSB-first on each sclk falling edge of a frame.
  initial sdata = 1'b0;
  initial sdata4 = 1'b0;
  always @(negedge cs_n) idx = 15;
  always @(negedge sclk) if (cs_n === 1'b0 && idx >= 0) begin sdata = word[idx]; idx--; end
  always @(negedge cs_n4) idx4 = 15;
  always @(negedge sclk4) if (cs_n4 === 1'b0 && idx4 >= 0) begin sdata4 = word4[idx4]; idx4--; end

  always @(posedge sclk) if (cs_n === 1'b0) rises++;
  always @(posedge sclk4) begin t_per4 = $time - t_prev4; t_prev4 = $time; end
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until data_valid; cyc = limit+1 on timeout.
  task automatic wait_dv(input bit use4, input int limit, output int cyc, output int low);
    cyc = 0;
    low = 0;
    while (cyc < limit) begin
      @(negedge clk);
      cyc++;
      if ((use4 ? cs_n4 : cs_n) === 1'b0) low++;
      if ((use4 ? data_valid4 : data_valid) === 1'b1) return;
    end
    cyc = limit + 1;
  endtask

  int cyc, low, bad, dv0, low0;

  initial begin
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with start low
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check("idle_data_out", data_out, 0);
    check("idle_frame_err", frame_err, 0);

    // Single frame 0x0ABC
    word = 16'h0ABC; rises = 0; dv0 = dv_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    low0 = (cs_n === 1'b0) ? 1 : 0;
    check("f1_busy", busy, 1);
    wait_dv(1'b0, 100, cyc, low);
    check("f1_latency", cyc, 33);
    check("f1_cs_low", low + low0, 33);
    check("f1_data", data_out, 12'hABC);
    check("f1_rises", rises, 16);
    check("f1_frame_err", frame_err, 0);
    @(negedge clk);
    check("f1_dv_single", data_valid, 0);
    repeat (5) @(negedge clk);
    check("f1_dv_count", dv_cnt - dv0, 1);
    check("f1_idle_busy", busy, 0);

    // Back-to-back frames with start held
    word = 16'h0123; dv0 = dv_cnt;
    start = 1'b1;
    @(negedge clk);
    wait_dv(1'b0, 100, cyc, low);
    check("b2b_lat", cyc, 33);
    check("b2b_data1", data_out, 12'h123);
    word = 16'h0FFF;
    wait_dv(1'b0, 100, cyc, low);
    start = 1'b0;
    check("b2b_period", cyc, 36);
    check("b2b_cs_high", cyc - low, 3);
    check("b2b_data2", data_out, 12'hFFF);
    repeat (10) @(negedge clk);
    check("b2b_stop_busy", busy, 0);
    check("b2b_dv_count", dv_cnt - dv0, 2);

    // CLK_DIV=4 instance
    word4 = 16'h0555;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_dv(1'b1, 400, cyc, low);
    check("div4_latency", cyc, 132);
    check("div4_data", data_out4, 12'h555);
    check("div4_sclk_period", 32'(t_per4), 80);
    repeat (10) @(negedge clk);
    check("div4_idle", busy4, 0);

    // Leading-zero check
    word = 16'hFABC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dv(1'b0, 100, cyc, low);
    check("zc_data", data_out, 12'hABC);
    check("zc_err", frame_err, ExpErr);
    repeat (5) @(negedge clk);
    check("zc_err_held", frame_err, ExpErr);

    // Next frame clears the flag; a start pulse mid-frame is ignored
    word = 16'h0001; dv0 = dv_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dv(1'b0, 100, cyc, low);
    check("mid_start_lat", cyc, 22);
    check("zc2_data", data_out, 12'h001);
    check("zc2_err", frame_err, 0);
    repeat (10) @(negedge clk);
    check("mid_start_no_queue", busy, 0);
    check("mid_start_dv_count", dv_cnt - dv0, 1);

    // Reset at bit 7 of a frame
    word = 16'h0ABC; rises = 0; dv0 = dv_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && rises < 7; i++) @(negedge clk);
    check("rst_reach_bit7", rises, 7);
    rst_n = 1'b0;
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 1);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_dv", dv_cnt - dv0, 0);
    check("rst_stays_idle", busy, 0);

    word = 16'h0321; rises = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_dv(1'b0, 100, cyc, low);
    check("post_rst_lat", cyc, 33);
    check("post_rst_data", data_out, 12'h321);
    check("post_rst_rises", rises, 16);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
